counter_scheduler: RTL
======================

# counter_scheduler

Shares one Size-bit interval counter between up to Requesters clients. Each client requests a timed window of len+1 clock cycles. A round-robin arbiter picks one winner, and the block holds that client's grant while the counter runs. It then pulses done, or aborted if the client withdrew early. The block sits between simulation-side requesters and the counter datapath, and it owns the counter's clear and compare sequencing.

## Interface
- Size, 5: counter width; window lengths are 0..2^Size-1.
- Requesters, 4: number of clients, 2..16; IdW = max(1, clog2(Requesters)).
- clock  input  1  rising-edge clock for all state.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- req  input  Requesters  per-client request level; hold high until done/aborted.
- len  input  Requesters*Size  packed lengths; client i uses bits [i*Size +: Size].
- grant  output  Requesters  one-hot owner of the counter; all-zero when idle.
- busy  output  1  high while any grant is high.
- count  output  Size  elapsed cycles of the current window; 0 when idle.
- done  output  1  one-cycle pulse; the window completed normally.
- aborted  output  1  one-cycle pulse; the owner dropped req before completion.
- done_id  output  IdW  index of the finishing client; valid while done or aborted is high.

## Operation
- Reset values:
  - grant=0, busy=0, count=0, done=0, aborted=0, done_id=0.
  - State IDLE.
  - Last-winner pointer = Requesters-1, so client 0 wins first.
- States: IDLE, RUN, FINISH.
- IDLE:
  - If any req bit is set at a rising edge, pick the first set bit searching upward from last+1 (mod Requesters).
  - Latch limit = len[winner], set grant[winner], count=0, last=winner, go to RUN.
  - With no request, stay in IDLE.
- RUN, evaluated at each edge in this priority order:
  - (a) req[owner]==0: clear grant, assert aborted, go to FINISH.
  - (b) count==limit: clear grant, assert done, go to FINISH.
  - (c) otherwise count <= count+1.
  - The compare happens before the increment, so count never wraps. With limit=2^Size-1, count reaches all-ones and stops.
- FINISH:
  - done or aborted is high for exactly this cycle. done_id = owner. count holds its final value.
  - Next edge: clear done, aborted and count, then go to IDLE. No arbitration happens in FINISH.
- len is sampled only on the grant edge. Later changes do not affect the running window.
- Requests from non-owners during RUN or FINISH are ignored until IDLE. They are not lost as long as they are held.
- Simultaneous events at the same edge:
  - Withdrawal and count==limit: aborted wins; done stays low.
  - Multiple requesters: round-robin only; there is no priority weighting.
- Reset asserted mid-window forces the reset values asynchronously. No done or aborted pulse is produced. After release, arbitration restarts from client 0.

## Timing
- Request to grant:
  - req high before edge E0 while in IDLE gives grant high after E0.
  - Grant stays high for limit+1 cycles, i.e. the edges E1..E(limit+1) occur in RUN.
- The done pulse starts after edge E(limit+1) and lasts one cycle.
- The next grant comes no earlier than 2 cycles after the previous grant falls (FINISH, then IDLE).
- Steady-state period per window: limit+3 cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Package counter_sched_pkg holds:
  - State encoding localparams: IDLE=2'd0, RUN=2'd1, FINISH=2'd2.
  - A helper function for IdW (clog2).
- Sub-module counter_rr_arbiter:
  - Purely combinational round-robin pick from req and last.
  - Outputs a one-hot winner, its index, and an any_req flag.
- The top level holds the FSM, limit register, count register and output registers.

## Test plan
- Reset then single request: req=4'b0001, len0=3 → grant=0001 for 4 cycles, count runs 0,1,2,3, then done=1 with done_id=0 for one cycle. busy falls with grant.
- Zero length: len2=0, req=4'b0100 → grant high for exactly 1 cycle, count stays 0, then done with done_id=2.
- Round-robin fairness: all four req held, every len=1 → grants go 0,1,2,3,0, each 2 cycles wide with 2-cycle gaps.
- Abort: req0 with len0=10, drop req0 when count=4 → grant falls at the next edge, aborted=1, done=0, done_id=0. Same edge as count==limit → aborted only.
- Max length: len=31, Size=5 → grant high for 32 cycles, count ends at 31 with no wrap, then done.
- Mid-window reset: assert reset at count=5 → all outputs 0 immediately with no pulse. After release, req=4'b0011 is granted to client 0 first.

Source files
------------

// File: rtl/counter_sched_pkg.sv
// rtl/counter_sched_pkg.sv - shared state encoding and sizing helper for counter_scheduler
package counter_sched_pkg;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] RUN    = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = IDLE,
    S_RUN    = RUN,
    S_FINISH = FINISH
  } state_t;

  // Client index width: clog2(n), but never narrower than one bit.
  function automatic int id_width(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) w = i + 1;
    end
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/counter_rr_arbiter.sv
// rtl/counter_rr_arbiter.sv - combinational round-robin pick starting after the last winner
module counter_rr_arbiter
  import counter_sched_pkg::*;
#(
  parameter int Requesters = 4,
  localparam int IdW = id_width(Requesters)
) (
  input  logic [Requesters-1:0] req,
  input  logic [IdW-1:0]        last,
  output logic [Requesters-1:0] winner,
  output logic [IdW-1:0]        winner_id,
  output logic                  any_req
);

  // Walk last+1, last+2, ... wrapping once; the first set request wins.
  always_comb begin
    int            cand;
    logic [IdW-1:0] cand_id;
    logic           found;
    cand      = 0;
    cand_id   = '0;
    found     = 1'b0;
    winner_id = '0;
    winner    = '0;
    for (int i = 1; i <= Requesters; i++) begin
      cand    = (int'(last) + i) % Requesters;
      cand_id = IdW'(cand);
      if (!found && req[cand_id]) begin
        found     = 1'b1;
        winner_id = cand_id;
      end
    end
    if (found) winner[winner_id] = 1'b1;
    any_req = found;
  end

endmodule

// File: rtl/counter_scheduler.sv
// rtl/counter_scheduler.sv - arbitrates one interval counter among several clients
module counter_scheduler
  import counter_sched_pkg::*;
#(
  parameter int Size       = 5,
  parameter int Requesters = 4,
  localparam int IdW = id_width(Requesters)
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [Requesters-1:0]      req,
  input  logic [Requesters*Size-1:0] len,
  output logic [Requesters-1:0]      grant,
  output logic                       busy,
  output logic [Size-1:0]            count,
  output logic                       done,
  output logic                       aborted,
  output logic [IdW-1:0]             done_id
);

  state_t                state_q, state_d;
  logic [Size-1:0]       limit_q, limit_d;
  logic [Size-1:0]       count_q, count_d;
  logic [IdW-1:0]        owner_q, owner_d;
  logic [IdW-1:0]        last_q, last_d;
  logic [Requesters-1:0] grant_q, grant_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  aborted_q, aborted_d;
  logic [IdW-1:0]        done_id_q, done_id_d;

  logic [Requesters-1:0] win;
  logic [IdW-1:0]        win_id;
  logic                  any_req;
  logic [Size-1:0]       win_len;

  counter_rr_arbiter #(
    .Requesters(Requesters)
  ) u_arb (
    .req      (req),
    .last     (last_q),
    .winner   (win),
    .winner_id(win_id),
    .any_req  (any_req)
  );

  // Select the winner's length field with constant part-selects only.
  always_comb begin
    win_len = '0;
    for (int i = 0; i < Requesters; i++) begin
      if (win_id == IdW'(i)) win_len = len[i*Size +: Size];
    end
  end

  // Next-state and next-output logic; abort has priority over completion.
  always_comb begin
    state_d   = state_q;
    limit_d   = limit_q;
    count_d   = count_q;
    owner_d   = owner_q;
    last_d    = last_q;
    grant_d   = grant_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;
    done_id_d = done_id_q;
    case (state_q)
      S_IDLE: begin
        if (any_req) begin
          limit_d = win_len;
          grant_d = win;
          count_d = '0;
          owner_d = win_id;
          last_d  = win_id;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (!req[owner_q]) begin
          grant_d   = '0;
          aborted_d = 1'b1;
          done_id_d = owner_q;
          state_d   = S_FINISH;
        end else if (count_q == limit_q) begin
          grant_d   = '0;
          done_d    = 1'b1;
          done_id_d = owner_q;
          state_d   = S_FINISH;
        end else begin
          count_d = count_q + Size'(1);
        end
      end
      S_FINISH: begin
        count_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        grant_d = '0;
        count_d = '0;
        state_d = S_IDLE;
      end
    endcase
    busy_d = |grant_d;
  end

  // State and output registers; reset points last at the top client so client 0 wins first.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      limit_q   <= '0;
      count_q   <= '0;
      owner_q   <= '0;
      last_q    <= IdW'(Requesters - 1);
      grant_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      limit_q   <= limit_d;
      count_q   <= count_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      grant_q   <= grant_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
      done_id_q <= done_id_d;
    end
  end

  assign grant   = grant_q;
  assign busy    = busy_q;
  assign count   = count_q;
  assign done    = done_q;
  assign aborted = aborted_q;
  assign done_id = done_id_q;

endmodule
